spi_reg_bank: RTL and testbench

Register bank and transaction sequencer fed by the SPI slave byte receiver. It frames each chip-select cycle into a command byte followed by data bytes, executes burst register writes and reads with address auto-increment, and supplies the read byte and output enable for the MISO shifter. It also exposes configuration to the frequency sampler and snapshots that sampler's 24-bit count.

---
 rtl/spi_reg_pkg.sv | 28 ++
 rtl/spi_reg_bank.sv | 153 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bank: register addresses, STATUS bit
// positions, command byte layout and the sequencer state encoding.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_ID     = 7'h00;
    localparam logic [6:0] ADDR_CTRL   = 7'h01;
    localparam logic [6:0] ADDR_THR_L  = 7'h02;
    localparam logic [6:0] ADDR_THR_H  = 7'h03;
    localparam logic [6:0] ADDR_STATUS = 7'h04;
    localparam logic [6:0] ADDR_FCNT_L = 7'h05;
    localparam logic [6:0] ADDR_FCNT_M = 7'h06;
    localparam logic [6:0] ADDR_FCNT_H = 7'h07;

    localparam int STAT_NEW  = 0;
    localparam int STAT_OVER = 1;
    localparam int STAT_AERR = 2;

    // Command byte: bit 7 set = read, clear = write; bits 6:0 = start address.
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } seq_state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// SPI register bank and transaction sequencer.
// Frames each chip-select cycle into a command byte plus data bytes, runs
// burst writes/reads with 7-bit wrapping address auto-increment, feeds the
// MISO shifter, and exposes configuration to / snapshots the frequency sampler.
//
// Ports:
//   sys_clk_25m, sys_rstn      clock, async active-low reset
//   spi_byte_vld, spi_wr_data  received byte strobe and value
//   spi_sel_end                chip-select deassert strobe
//   spi_rd_data, spi_out_oe    byte for MISO shifter and its drive enable
//   freq_cnt, freq_cnt_vld     live sampler count and its update strobe
//   cfg_ctrl, cfg_thresh       CTRL register, {THR_H, THR_L}
//   irq                        level interrupt
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame in progress; next byte is a command
// CMD     | command decode; decoded in the byte's own cycle, so never held
// WDATA   | each byte is written to addr, then addr increments
// RDATA   | each byte loads spi_rd_data from addr, then addr increments
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] ID_VAL   = 8'h5A,
    parameter int         NUM_REGS = 8
) (
    input  logic        sys_clk_25m,
    input  logic        sys_rstn,
    input  logic        spi_byte_vld,
    input  logic [7:0]  spi_wr_data,
    input  logic        spi_sel_end,
    output logic [7:0]  spi_rd_data,
    output logic        spi_out_oe,
    input  logic [23:0] freq_cnt,
    input  logic        freq_cnt_vld,
    output logic [7:0]  cfg_ctrl,
    output logic [15:0] cfg_thresh,
    output logic        irq
);

    seq_state_t  state, state_nxt;
    logic [6:0]  addr;
    logic [7:0]  reg_ctrl, reg_thr_l, reg_thr_h;
    logic [2:0]  status, stat_set, stat_clr;
    logic [23:0] shadow;

    logic        byte_take, cmd_take, wr_take, rd_load_cmd, rd_load;
    logic [6:0]  acc_addr;
    logic        acc_valid;
    logic [7:0]  rd_mux;

    // A byte coincident with chip-select deassert is dropped entirely.
    assign byte_take   = spi_byte_vld & ~spi_sel_end;
    assign cmd_take    = byte_take & ((state == ST_IDLE) || (state == ST_CMD));
    assign wr_take     = byte_take & (state == ST_WDATA);
    assign rd_load_cmd = cmd_take & spi_wr_data[CMD_RW_BIT];
    assign rd_load     = rd_load_cmd | (byte_take & (state == ST_RDATA));

    // The command byte's read is served from its own address in the same
    // cycle, which gives one-cycle latency for the first read byte.
    assign acc_addr  = cmd_take ? spi_wr_data[6:0] : addr;
    assign acc_valid = (int'(acc_addr) < NUM_REGS);

    always_ff @(posedge sys_clk_25m or negedge sys_rstn) begin
        if (!sys_rstn) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (spi_sel_end) begin
            state_nxt = ST_IDLE;
        end else if (spi_byte_vld) begin
            case (state)
                ST_IDLE, ST_CMD: state_nxt = spi_wr_data[CMD_RW_BIT] ? ST_RDATA : ST_WDATA;
                default:         state_nxt = state;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (acc_valid) begin
            case (acc_addr)
                ADDR_ID:     rd_mux = ID_VAL;
                ADDR_CTRL:   rd_mux = reg_ctrl;
                ADDR_THR_L:  rd_mux = reg_thr_l;
                ADDR_THR_H:  rd_mux = reg_thr_h;
                ADDR_STATUS: rd_mux = {5'b0, status};
                ADDR_FCNT_L: rd_mux = freq_cnt[7:0];
                ADDR_FCNT_M: rd_mux = shadow[15:8];
                ADDR_FCNT_H: rd_mux = shadow[23:16];
                default:     rd_mux = 8'h00;
            endcase
        end
    end

    always_comb begin
        stat_set            = 3'b000;
        stat_set[STAT_NEW]  = freq_cnt_vld;
        stat_set[STAT_OVER] = freq_cnt_vld & (freq_cnt[23:8] > {reg_thr_h, reg_thr_l});
        stat_set[STAT_AERR] = (wr_take | rd_load) & ~acc_valid;
        stat_clr            = 3'b000;
        if (wr_take && acc_valid && (acc_addr == ADDR_STATUS))
            stat_clr = spi_wr_data[2:0];
    end

    always_ff @(posedge sys_clk_25m or negedge sys_rstn) begin
        if (!sys_rstn) begin
            addr        <= 7'h00;
            spi_rd_data <= 8'h00;
            spi_out_oe  <= 1'b0;
            reg_ctrl    <= 8'h00;
            reg_thr_l   <= 8'h00;
            reg_thr_h   <= 8'h00;
            status      <= 3'b000;
            shadow      <= 24'h000000;
        end else begin
            // Set wins over a simultaneous clear of the same bit.
            status <= (status & ~stat_clr) | stat_set;

            if (cmd_take)
                addr <= rd_load_cmd ? spi_wr_data[6:0] + 7'd1 : spi_wr_data[6:0];
            else if (wr_take || rd_load)
                addr <= addr + 7'd1;

            if (rd_load) begin
                spi_rd_data <= rd_mux;
                // Capture the full count when the low byte goes out, so the
                // upper bytes of a burst are coherent with it.
                if (acc_valid && (acc_addr == ADDR_FCNT_L))
                    shadow <= freq_cnt;
            end

            if (spi_sel_end)      spi_out_oe <= 1'b0;
            else if (rd_load_cmd) spi_out_oe <= 1'b1;

            if (wr_take && acc_valid) begin
                case (acc_addr)
                    ADDR_CTRL:  reg_ctrl  <= spi_wr_data;
                    ADDR_THR_L: reg_thr_l <= spi_wr_data;
                    ADDR_THR_H: reg_thr_h <= spi_wr_data;
                    default:    ;
                endcase
            end
        end
    end

    assign cfg_ctrl   = reg_ctrl;
    assign cfg_thresh = {reg_thr_h, reg_thr_l};
    assign irq        = reg_ctrl[7] & (status[STAT_NEW] | status[STAT_OVER]);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank with hand-computed expected values.
module tb_spi_reg_bank;

    logic        clk;
    logic        rst_n;
    logic        byte_vld;
    logic [7:0]  wr_data;
    logic        sel_end;
    logic [7:0]  rd_data;
    logic        out_oe;
    logic [23:0] fcnt;
    logic        fcnt_vld;
    logic [7:0]  ctrl;
    logic [15:0] thresh;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    spi_reg_bank #(.ID_VAL(8'h5A), .NUM_REGS(8)) dut (
        .sys_clk_25m  (clk),
        .sys_rstn     (rst_n),
        .spi_byte_vld (byte_vld),
        .spi_wr_data  (wr_data),
        .spi_sel_end  (sel_end),
        .spi_rd_data  (rd_data),
        .spi_out_oe   (out_oe),
        .freq_cnt     (fcnt),
        .freq_cnt_vld (fcnt_vld),
        .cfg_ctrl     (ctrl),
        .cfg_thresh   (thresh),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling
    // edge that follows the capturing rising edge.
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        byte_vld = 1'b1;
        wr_data  = b;
        @(negedge clk);
        byte_vld = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        sel_end = 1'b1;
        @(negedge clk);
        sel_end = 1'b0;
    endtask

    task automatic read_reg(input logic [6:0] a, input string tag, input logic [7:0] exp);
        put({1'b1, a});
        chk(tag, rd_data, exp);
        end_frame();
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        put({1'b0, a});
        put(d);
        end_frame();
    endtask

    initial begin
        rst_n    = 1'b0;
        byte_vld = 1'b0;
        wr_data  = 8'h00;
        sel_end  = 1'b0;
        fcnt     = 24'h0;
        fcnt_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_oe", out_oe, 1'b0);
        chk("rst_ctrl", ctrl, 8'h00);
        chk("rst_thresh", thresh, 16'h0000);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // ID read, then dummy byte advances to CTRL
        put(8'h80);
        chk("id_read", rd_data, 8'h5A);
        chk("id_oe", out_oe, 1'b1);
        put(8'h00);
        chk("burst_ctrl_read", rd_data, 8'h00);
        end_frame();
        chk("oe_after_end", out_oe, 1'b0);

        // write burst CTRL, THR_L, THR_H
        put(8'h01);
        put(8'h81);
        chk("ctrl_write", ctrl, 8'h81);
        put(8'h34);
        put(8'h12);
        chk("thresh_write", thresh, 16'h1234);
        chk("irq_no_status", irq, 1'b0);
        end_frame();

        // 0x1235 > 0x1234 -> NEW and OVER
        fcnt = 24'h123500;
        @(negedge clk);
        fcnt_vld = 1'b1;
        @(negedge clk);
        fcnt_vld = 1'b0;
        chk("irq_set", irq, 1'b1);
        read_reg(7'h04, "status_new_over", 8'h03);
        write_reg(7'h04, 8'h01);
        chk("irq_over_only", irq, 1'b1);
        read_reg(7'h04, "status_over", 8'h02);
        write_reg(7'h04, 8'h02);
        chk("irq_cleared", irq, 1'b0);
        read_reg(7'h04, "status_clear", 8'h00);

        // FCNT snapshot burst; live count changes after the first load
        fcnt = 24'h123456;
        put(8'h85);
        chk("fcnt_l", rd_data, 8'h56);
        fcnt = 24'hABCDEF;
        put(8'h00);
        chk("fcnt_m_shadow", rd_data, 8'h34);
        put(8'h00);
        chk("fcnt_h_shadow", rd_data, 8'h12);
        put(8'h00);
        chk("unimpl_read", rd_data, 8'h00);
        end_frame();
        read_reg(7'h04, "aerr_on_read", 8'h04);
        write_reg(7'h04, 8'h04);

        // write at 0x7F wraps to ID
        put(8'h7F);
        put(8'hAA);
        put(8'h55);
        end_frame();
        read_reg(7'h04, "aerr_on_write", 8'h04);
        read_reg(7'h00, "id_unchanged", 8'h5A);
        write_reg(7'h04, 8'h04);
        write_reg(7'h01, 8'h42);
        chk("ctrl_after_wrap", ctrl, 8'h42);

        // byte coincident with sel_end is dropped
        put(8'h02);
        put(8'h77);
        chk("thr_l_write", thresh, 16'h1277);
        @(negedge clk);
        byte_vld = 1'b1;
        wr_data  = 8'h99;
        sel_end  = 1'b1;
        @(negedge clk);
        byte_vld = 1'b0;
        sel_end  = 1'b0;
        chk("coincident_no_write", thresh, 16'h1277);
        put(8'h82);
        chk("idle_after_coincident", rd_data, 8'h77);
        chk("oe_new_read", out_oe, 1'b1);
        end_frame();

        // reset mid-burst
        write_reg(7'h01, 8'hFF);
        chk("ctrl_ff", ctrl, 8'hFF);
        put(8'h83);
        chk("thr_h_read", rd_data, 8'h12);
        put(8'h00);
        #5 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", ctrl, 8'h00);
        chk("midrst_thresh", thresh, 16'h0000);
        chk("midrst_rd_data", rd_data, 8'h00);
        chk("midrst_oe", out_oe, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_reg(7'h03, "post_rst_thr_h", 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
